data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Initiator side of the word-addressed data memory: the load/store unit between the MIPS datapath and the data memory port.
- Accepts one load/store request at a time (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Loads: drives the word address, then extracts and extends the addressed byte or halfword.
- Stores: sub-word stores use read-modify-write, because the memory writes whole 32-bit words only.

Parameters:
- ADDR_W, 12, byte-address width of the memory port; word index is mem_addr[ADDR_W-1:2].
- SIGN_EXT_DEFAULT, 1, load sign-extension for lb/lh; lbu/lhu always zero-extend.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; 1 only in IDLE.
- req_op  in  3  0=lb 1=lbu 2=lh 3=lhu 4=lw 5=sb 6=sh 7=sw.
- req_addr  in  32  byte address; bits above ADDR_W-1 ignored.
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- mem_addr  out  ADDR_W  byte address to memory, registered.
- mem_wdata  out  32  word to write, registered.
- mem_we  out  1  write enable; memory writes on the clk edge while high.
- mem_rdata  in  32  combinational read data for mem_addr.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  load result; 0 for stores.
- resp_fault  out  1  misaligned access (only with the optional feature).

Behaviour:
- Reset values (immediate on rst_n low): state IDLE; mem_addr=0, mem_wdata=0, mem_we=0, resp_valid=0, resp_data=0, resp_fault=0. req_ready=1 once in IDLE.
- Byte lanes are little-endian: lane k = addr[1:0]==k occupies bits [8k+7:8k]. Halfword at addr[1]=h occupies [16h+15:16h].
- Accept: handshake when req_valid && req_ready. Latch op, addr, wdata. Drive mem_addr = req_addr[ADDR_W-1:0] and mem_we = 0.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Transitions from IDLE on accept:
  - lw/lh/lhu/lb/lbu -> LOAD.
  - sw -> WRITE, with mem_wdata = wdata and mem_we = 1 registered.
  - sb/sh -> RMW_RD.
- LOAD (1 cycle): sample mem_rdata, select and extend the lane, register into resp_data -> RESP.
- RMW_RD (1 cycle): merge the store lane(s) into mem_rdata, register into mem_wdata, set mem_we = 1 -> WRITE.
- WRITE (1 cycle): mem_we high for exactly this cycle; the write occurs at the edge ending it. Then mem_we = 0 -> RESP.
- RESP (1 cycle): resp_valid = 1 -> IDLE. resp_data and resp_fault hold until the next RESP.
- Latency from the accept edge to resp_valid high:
  - loads: 2 cycles;
  - sw: 2 cycles;
  - sb/sh: 3 cycles.
- Max throughput is one request per 3 (loads/sw) or 4 (sb/sh) cycles.
- No backpressure on the response side.
- req_valid while not IDLE is ignored (req_ready = 0); the requester holds it.
- mem_we is never high outside WRITE, and never high in the cycle after reset release.
- Reset mid-operation aborts the access; a pending WRITE is not performed if rst_n falls before its edge.
- Address wrap: addresses beyond 2^ADDR_W alias modulo 2^ADDR_W.
- A store followed by a load to the same word returns the new data (the sequential ordering guarantees this).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, go IDLE -> RESP directly.
  - resp_fault = 1, resp_data = 0, no memory write.
  - Aligned accesses have resp_fault = 0.
- Undefined:
  - No fault logic; resp_fault is tied 0.
  - Halfword accesses use addr[0]=0 and word accesses use addr[1:0]=0 (aligned down).

Test Plan:
- Reset with rst_n=0 mid-sb in RMW_RD -> mem_we stays 0, memory word unchanged, resp_valid never pulses, req_ready=1 after release.
- sw 0xDEADBEEF @0x010, then lw @0x010 -> mem_we high exactly 1 cycle; resp_data=0xDEADBEEF two cycles after the lw accept.
- Word@0x010=0xDEADBEEF; lb @0x013 -> 0xFFFFFFDE; lbu @0x013 -> 0x000000DE; lh @0x010 -> 0xFFFFBEEF; lhu @0x012 -> 0x0000DEAD.
- sb 0x55 @0x011 on 0xDEADBEEF -> word becomes 0xDEAD55EF; resp_valid 3 cycles after accept; mem_we high 1 cycle.
- Misaligned lw @0x012 -> with MEM_MISALIGN_TRAP_EN: resp_fault=1, resp_data=0, no memory access; without: reads word @0x010.
- Back-to-back req_valid held high -> second accept occurs only in the cycle after resp_valid; no request dropped or duplicated.

Source files
------------

// File: rtl/data_mem_access_unit_if.sv
// data_mem_access_unit_if: request, word-memory and response signals of the load/store unit
interface data_mem_access_unit_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_fault;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_we, resp_valid, resp_data, resp_fault
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_we, resp_valid, resp_data, resp_fault
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: MIPS load/store unit over a word-write memory; MEM_MISALIGN_TRAP_EN enables misalignment faults
module data_mem_access_unit #(
  parameter int ADDR_W           = 12,
  parameter bit SIGN_EXT_DEFAULT = 1'b1
) (
  input logic clk,
  input logic rst_n,
  data_mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  localparam logic [2:0] LH = 3'd2, LHU = 3'd3, LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;
  state_t      state, state_d;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        accept, fault, sext, unused_addr;
  logic [4:0]  sh_b, sh_h;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] load_data, mask, sdata, merged;
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign accept         = bus.req_valid && bus.req_ready;
  assign unused_addr    = ^bus.req_addr[31:ADDR_W];
`ifdef MEM_MISALIGN_TRAP_EN
  assign fault = ((bus.req_op == LH || bus.req_op == LHU || bus.req_op == SH) && bus.req_addr[0]) ||
                 ((bus.req_op == LW || bus.req_op == SW) && |bus.req_addr[1:0]);
`else
  assign fault = 1'b0;
`endif
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = !accept ? IDLE : fault ? RESP : bus.req_op == SW ? WRITE :
                         bus.req_op >= SB ? RMW_RD : LOAD;
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // Lane selection ignores the low address bits the access size does not use (align-down).
  assign sh_b      = {lane_q, 3'b000};
  assign sh_h      = {lane_q[1], 4'b0000};
  assign rd_b      = bus.mem_rdata[sh_b +: 8];
  assign rd_h      = bus.mem_rdata[sh_h +: 16];
  assign sext      = SIGN_EXT_DEFAULT && !op_q[0];
  assign load_data = op_q == LW ? bus.mem_rdata :
                     op_q[1] ? {{16{sext && rd_h[15]}}, rd_h} : {{24{sext && rd_b[7]}}, rd_b};
  assign mask      = op_q == SB ? 32'h0000_00FF << sh_b : 32'h0000_FFFF << sh_h;
  assign sdata     = op_q == SB ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
  assign merged    = (bus.mem_rdata & ~mask) | (sdata & mask);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      lane_q        <= '0;
      wdata_q       <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.resp_data <= '0;
    end else begin
      state      <= state_d;
      bus.mem_we <= state_d == WRITE;
      if (accept) begin
        op_q         <= bus.req_op;
        lane_q       <= bus.req_addr[1:0];
        wdata_q      <= bus.req_wdata;
        bus.mem_addr <= bus.req_addr[ADDR_W-1:0];
      end
      if (state_d == WRITE) bus.mem_wdata <= state == RMW_RD ? merged : bus.req_wdata;
      if (state_d == RESP) bus.resp_data <= state == LOAD ? load_data : 32'h0;
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  // Only a faulting request skips straight from IDLE to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.resp_fault <= 1'b0;
    else if (state_d == RESP) bus.resp_fault <= state == IDLE;
  end
`else
  assign bus.resp_fault = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed self-checking bench for data_mem_access_unit
module tb_data_mem_access_unit;
  localparam int ADDR_W = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int rv_cnt = 0;
  int acc_cnt = 0;
  logic [31:0] mem [0:1023];
  data_mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();
  data_mem_access_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] data, output logic fault);
    int k;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data  = bus.resp_data;
    fault = bus.resp_fault;
  endtask
  initial begin
    int lat, w0, r0, a0;
    logic [31:0] d;
    logic f;
    logic [5:0] rdy_log, rv_log;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", bus.req_ready, 1);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset resp_valid", bus.resp_valid, 0);
    chk("reset resp_data", bus.resp_data, 0);
    chk("reset resp_fault", bus.resp_fault, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset mem_we", bus.mem_we, 0);
    w0 = we_cnt;
    issue(3'd7, 32'h010, 32'hDEADBEEF, lat, d, f);
    chk("sw latency", lat, 2);
    chk("sw we cycles", we_cnt - w0, 1);
    chk("sw memory", mem[4], 32'hDEADBEEF);
    chk("sw resp_data", d, 0);
    issue(3'd4, 32'h010, 0, lat, d, f);
    chk("lw latency", lat, 2);
    chk("lw data", d, 32'hDEADBEEF);
    chk("lw fault", f, 0);
    issue(3'd0, 32'h013, 0, lat, d, f);
    chk("lb @013", d, 32'hFFFFFFDE);
    issue(3'd1, 32'h013, 0, lat, d, f);
    chk("lbu @013", d, 32'h000000DE);
    issue(3'd2, 32'h010, 0, lat, d, f);
    chk("lh @010", d, 32'hFFFFBEEF);
    issue(3'd3, 32'h012, 0, lat, d, f);
    chk("lhu @012", d, 32'h0000DEAD);
    chk("load latency", lat, 2);
    w0 = we_cnt;
    issue(3'd5, 32'h011, 32'hAABBCC55, lat, d, f);
    chk("sb latency", lat, 3);
    chk("sb we cycles", we_cnt - w0, 1);
    chk("sb memory", mem[4], 32'hDEAD55EF);
    chk("sb resp_data", d, 0);
    issue(3'd6, 32'h012, 32'hFFFF1234, lat, d, f);
    chk("sh latency", lat, 3);
    chk("sh memory", mem[4], 32'h123455EF);
    w0 = we_cnt;
    issue(3'd4, 32'h012, 0, lat, d, f);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misaligned lw fault", f, 1);
    chk("misaligned lw data", d, 0);
    chk("misaligned lw latency", lat, 1);
    w0 = we_cnt;
    issue(3'd7, 32'h011, 32'h0BADF00D, lat, d, f);
    chk("misaligned sw fault", f, 1);
    chk("misaligned sw no write", we_cnt - w0, 0);
    chk("misaligned sw memory", mem[4], 32'h123455EF);
`else
    chk("misaligned lw fault", f, 0);
    chk("misaligned lw data", d, 32'h123455EF);
    chk("misaligned lw latency", lat, 2);
`endif
    issue(3'd7, 32'h1014, 32'hCAFEF00D, lat, d, f);
    chk("wrap sw memory", mem[5], 32'hCAFEF00D);
    issue(3'd4, 32'h014, 0, lat, d, f);
    chk("wrap lw data", d, 32'hCAFEF00D);
    chk("aligned fault", f, 0);
    @(negedge clk);
    a0 = acc_cnt;
    r0 = rv_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_addr  = 32'h014;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rdy_log[k] = bus.req_ready;
      rv_log[k]  = bus.resp_valid;
      if (k == 5) bus.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b ready pattern", rdy_log, 6'b100100);
    chk("b2b resp pattern", rv_log, 6'b010010);
    chk("b2b accepts", acc_cnt - a0, 2);
    chk("b2b responses", rv_cnt - r0, 2);
    w0 = we_cnt;
    r0 = rv_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd5;
    bus.req_addr  = 32'h010;
    bus.req_wdata = 32'h00000077;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmw_rd ready", bus.req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we", bus.mem_we, 0);
    chk("abort resp_data", bus.resp_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no write", we_cnt - w0, 0);
    chk("abort no resp", rv_cnt - r0, 0);
    chk("abort memory", mem[4], 32'h123455EF);
    chk("abort ready", bus.req_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
